// File: rtl/adv_input_conditioner.sv
// Input front end for the adventure-game room FSM: synchronises and debounces
// the buttons and v switch, then turns each accepted direction press into one pulse.
module adv_input_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  input  logic sw_v,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic v,
  output logic conflict
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [4:0] raw;
  logic [4:0] db;
  logic [3:0] db_d;
  logic [3:0] rise;
  logic [2:0] cnt_r;
  logic       lock;

  // Channel order: 0=n, 1=s, 2=e, 3=w, 4=v
  assign raw = {sw_v, btn_w, btn_e, btn_s, btn_n};

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_ch
      logic             q1;
      logic             q2;
      logic             db_reg;
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q1     <= 1'b0;
          q2     <= 1'b0;
          db_reg <= 1'b0;
          cnt    <= '0;
        end else begin
          q1 <= raw[gi];
          q2 <= q1;
          // Any return of q2 to the settled level restarts the stability count
          if (q2 == db_reg) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            db_reg <= q2;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end

      assign db[gi] = db_reg;
    end
  endgenerate

  assign rise  = db[3:0] & ~db_d;
  assign cnt_r = {2'b00, rise[0]} + {2'b00, rise[1]} + {2'b00, rise[2]} + {2'b00, rise[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_d     <= '0;
      lock     <= 1'b0;
      n        <= 1'b0;
      s        <= 1'b0;
      e        <= 1'b0;
      w        <= 1'b0;
      v        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      db_d     <= db[3:0];
      v        <= db[4];
      n        <= 1'b0;
      s        <= 1'b0;
      e        <= 1'b0;
      w        <= 1'b0;
      conflict <= 1'b0;
      if (!lock && cnt_r == 3'd1) begin
        n    <= rise[0];
        s    <= rise[1];
        e    <= rise[2];
        w    <= rise[3];
        lock <= 1'b1;
      end else if (!lock && cnt_r >= 3'd2) begin
        conflict <= 1'b1;
        lock     <= 1'b1;
      end else if (db[3:0] == 4'b0000 && rise == 4'b0000) begin
        // Re-arm only once every direction is released and settled
        lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adv_input_conditioner.sv
// Self-checking bench: directed scenarios plus random button activity, compared
// each cycle against a window-based reference model of the conditioner.
module tb_adv_input_conditioner;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0, sw_v = 1'b0;
  logic n, s, e, w, v, conflict;

  int errors = 0;
  int checks = 0;

  adv_input_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w), .sw_v(sw_v),
    .n(n), .s(s), .e(e), .w(w), .v(v), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples per edge since reset; a settled level flips
  // when the last DB synchronised samples (raw two edges earlier) all disagree with it.
  bit       hist [5][$];
  bit [4:0] m_db;
  bit [3:0] m_db_d;
  bit       m_lock;
  bit [5:0] exp_out;  // {n,s,e,w,conflict,v}

  function automatic bit seen(int ch, int t);
    if (t - 2 < 0) return 1'b0;
    return hist[ch][t-2];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 5; c++) hist[c].delete();
    m_db = '0;
    m_db_d = '0;
    m_lock = 1'b0;
    exp_out = '0;
  endtask

  task automatic model_edge();
    bit [4:0] rawv;
    bit [4:0] nxt_db;
    bit [3:0] r;
    int nr;
    int t;
    bit flip;
    if (reset) begin
      model_reset();
      return;
    end
    rawv = {sw_v, btn_w, btn_e, btn_s, btn_n};
    for (int c = 0; c < 5; c++) hist[c].push_back(rawv[c]);
    t = hist[0].size() - 1;
    nxt_db = m_db;
    for (int c = 0; c < 5; c++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++)
        if (seen(c, t - j) == m_db[c]) flip = 1'b0;
      if (flip) nxt_db[c] = ~m_db[c];
    end
    r = m_db[3:0] & ~m_db_d;
    nr = $countones(r);
    exp_out = {5'b0, m_db[4]};
    if (!m_lock && nr == 1) begin
      exp_out[5:2] = {r[0], r[1], r[2], r[3]};
      m_lock = 1'b1;
    end else if (!m_lock && nr >= 2) begin
      exp_out[1] = 1'b1;
      m_lock = 1'b1;
    end else if (m_db[3:0] == 4'b0 && nr == 0) begin
      m_lock = 1'b0;
    end
    m_db_d = m_db[3:0];
    m_db = nxt_db;
  endtask

  task automatic check(string tag);
    checks++;
    assert ({n, s, e, w, conflict, v} === exp_out) else begin
      errors++;
      $error("FAIL %s: observed {n,s,e,w,conflict,v}=%b expected=%b", tag, {n, s, e, w, conflict, v}, exp_out);
    end
    checks++;
    assert ($countones({n, s, e, w, conflict}) <= 1) else begin
      errors++;
      $error("FAIL %s_onehot: observed=%b expected at most one high", tag, {n, s, e, w, conflict});
    end
  endtask

  task automatic expect_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic idle(int cycles, string tag);
    for (int i = 0; i < cycles; i++) tick(tag);
  endtask

  task automatic do_reset(int cycles);
    reset = 1'b1;
    #1;
    model_reset();
    check("reset_async");
    idle(cycles, "reset_held");
    reset = 1'b0;
  endtask

  // Runs cycles ticks, returning the index of the first pulse on sel and the pulse count
  task automatic watch(int cycles, int sel, string tag, output int first, output int count);
    bit [5:0] o;
    first = -1;
    count = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(tag);
      o = {n, s, e, w, conflict, v};
      if (o[sel]) begin
        if (first < 0) first = i;
        count++;
      end
    end
  endtask

  localparam int SN = 5, SS = 4, SE = 3, SW = 2, SC = 1, SV = 0;

  initial begin
    int first, count;
    bit [6:0] bounce;
    bit [4:0] pat;
    model_reset();

    // 1: single north press held
    do_reset(2);
    btn_n = 1'b1;
    watch(20, SN, "t1_hold", first, count);
    expect_int("t1_n_edge", first, 6);
    expect_int("t1_n_count", count, 1);
    btn_n = 1'b0;
    idle(10, "t1_release");

    // 2: bounce on east never accepted, then steady press
    bounce = 7'b0111011;  // applied LSB first: 1,1,0,1,1,1,0
    count = 0;
    for (int i = 0; i < 7; i++) begin
      btn_e = bounce[i];
      tick("t2_bounce");
      if (e) count++;
    end
    expect_int("t2_bounce_no_e", count, 0);
    btn_e = 1'b1;
    watch(12, SE, "t2_steady", first, count);
    expect_int("t2_e_edge", first, DB + 2);
    expect_int("t2_e_count", count, 1);
    btn_e = 1'b0;
    idle(10, "t2_release");

    // 3: simultaneous south+east is a conflict, then west alone works
    btn_s = 1'b1;
    btn_e = 1'b1;
    watch(12, SC, "t3_conflict", first, count);
    expect_int("t3_conflict_edge", first, 6);
    expect_int("t3_conflict_count", count, 1);
    btn_s = 1'b0;
    btn_e = 1'b0;
    idle(10, "t3_release");
    btn_w = 1'b1;
    watch(12, SW, "t3_w", first, count);
    expect_int("t3_w_count", count, 1);
    btn_w = 1'b0;
    idle(10, "t3_w_release");

    // 4: lock blocks a second press while east is held
    btn_e = 1'b1;
    watch(10, SE, "t4_e", first, count);
    expect_int("t4_e_count", count, 1);
    btn_n = 1'b1;
    watch(12, SN, "t4_locked", first, count);
    expect_int("t4_n_blocked", count, 0);
    btn_n = 1'b0;
    btn_e = 1'b0;
    idle(10, "t4_release");
    btn_n = 1'b1;
    watch(12, SN, "t4_n_after", first, count);
    expect_int("t4_n_count", count, 1);
    btn_n = 1'b0;
    idle(10, "t4_n_release");

    // 5: reset mid-debounce, then reset while locked
    btn_w = 1'b1;
    idle(3, "t5_pre");
    do_reset(2);
    watch(12, SW, "t5_after_reset", first, count);
    expect_int("t5_w_edge", first, 6);
    expect_int("t5_w_count", count, 1);
    btn_w = 1'b0;
    idle(10, "t5_release");
    btn_e = 1'b1;
    idle(10, "t5_e_lock");
    do_reset(2);
    watch(12, SE, "t5_e_relock", first, count);
    expect_int("t5_lock_cleared", count, 1);
    btn_e = 1'b0;
    idle(10, "t5_e_release");

    // 6: v level with concurrent conflict
    sw_v = 1'b1;
    watch(8, SV, "t6_v_rise", first, count);
    expect_int("t6_v_edge", first, 6);
    btn_s = 1'b1;
    btn_n = 1'b1;
    watch(12, SV, "t6_v_hold", first, count);
    expect_int("t6_v_held", count, 12);
    btn_s = 1'b0;
    btn_n = 1'b0;
    sw_v = 1'b0;
    count = 0;
    for (int i = 0; i < 10; i++) begin
      tick("t6_v_fall");
      if (!v && count == 0) begin
        expect_int("t6_v_fall_edge", i, 6);
        count = 1;
      end
    end
    expect_int("t6_v_fell", count, 1);
    idle(10, "t6_idle");

    // Random activity: held patterns of random length, occasional bounce and reset
    for (int seg = 0; seg < 120; seg++) begin
      pat = 5'($urandom);
      if ($urandom_range(0, 3) != 0) pat[3:0] = 4'(1 << $urandom_range(0, 3)) & {4{pat[0]}};
      {sw_v, btn_w, btn_e, btn_s, btn_n} = pat;
      if ($urandom_range(0, 19) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        idle($urandom_range(1, 12), "rand");
      end
    end
    {sw_v, btn_w, btn_e, btn_s, btn_n} = 5'b0;
    idle(12, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
